// File: rtl/instr_fetch_queue.sv
// Instruction prefetch queue: 2-entry FIFO fed by a fixed 1-cycle-latency instruction memory.
// Define IFETCH_STATS_EN to add the fetch_count output (saturating count of accepted pops).
module instr_fetch_queue #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_data,
    output logic [15:0]       iin,
    output logic              iin_valid,
    input  logic              instr_done,
    input  logic              branch_en,
    input  logic [ADDR_W-1:0] branch_addr,
    input  logic              halt
`ifdef IFETCH_STATS_EN
    ,
    output logic [15:0]       fetch_count
`endif
);

    typedef enum logic {StRun, StHalted} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [1:0]        count_q;
    logic              outstanding_q;
    logic [15:0]       head_q;
    logic [15:0]       tail_q;

    logic room;
    logic push;
    logic pop;

    always_comb begin
        // Space must be reserved for the read already in flight.
        room      = (count_q == 2'd0) || ((count_q == 2'd1) && !outstanding_q);
        mem_rd    = (state_q == StRun) && !reset && !branch_en && room;
        mem_addr  = pc_q;
        iin       = head_q;
        iin_valid = (count_q != 2'd0);
        push      = outstanding_q && !branch_en;
        pop       = instr_done && iin_valid && !branch_en;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StRun;
        end else begin
            unique case (state_q)
                StRun:    if (halt)  state_q <= StHalted;
                StHalted: if (!halt) state_q <= StRun;
                default:  state_q <= StRun;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q          <= ADDR_W'(RESET_PC);
            outstanding_q <= 1'b0;
        end else begin
            outstanding_q <= mem_rd;
            if (branch_en) begin
                pc_q <= branch_addr;
            end else if (mem_rd) begin
                pc_q <= pc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= 2'd0;
        end else if (branch_en) begin
            count_q <= 2'd0;
        end else if (push && !pop) begin
            count_q <= count_q + 2'd1;
        end else if (pop && !push) begin
            count_q <= count_q - 2'd1;
        end
    end

    // head_q is always the oldest entry; a pop shifts the tail forward.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q <= 16'h0000;
            tail_q <= 16'h0000;
        end else if (!branch_en) begin
            if (pop) begin
                if (push && (count_q == 2'd1)) begin
                    head_q <= mem_data;
                end else begin
                    head_q <= tail_q;
                    if (push) tail_q <= mem_data;
                end
            end else if (push) begin
                if (count_q == 2'd0) head_q <= mem_data;
                else                 tail_q <= mem_data;
            end
        end
    end

`ifdef IFETCH_STATS_EN
    logic [15:0] fetch_count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_count_q <= 16'h0000;
        end else if (pop && (fetch_count_q != 16'hFFFF)) begin
            fetch_count_q <= fetch_count_q + 16'h0001;
        end
    end

    assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: memory word k = 16'h1000 + k, scoreboard of popped words.
// Checks fetch_count as well when IFETCH_STATS_EN is defined.
module tb_instr_fetch_queue;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_rd;
    logic [7:0]  mem_addr;
    logic [15:0] mem_data = 16'h0000;
    logic [15:0] iin;
    logic        iin_valid;
    logic        instr_done;
    logic        branch_en;
    logic [7:0]  branch_addr;
    logic        halt;
`ifdef IFETCH_STATS_EN
    logic [15:0] fetch_count;
`endif

    int tests = 0;
    int fails = 0;
    logic [15:0] exp_q[$];

    instr_fetch_queue #(.ADDR_W(8), .RESET_PC(0)) dut (
        .clock       (clock),
        .reset       (reset),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .iin         (iin),
        .iin_valid   (iin_valid),
        .instr_done  (instr_done),
        .branch_en   (branch_en),
        .branch_addr (branch_addr),
        .halt        (halt)
`ifdef IFETCH_STATS_EN
        ,
        .fetch_count (fetch_count)
`endif
    );

    always #5 clock = ~clock;

    // Instruction memory, 1-cycle read latency.
    always @(posedge clock) begin
        if (mem_rd) mem_data <= 16'h1000 + {8'h00, mem_addr};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pop_pulse();
        instr_done = 1'b1;
        step();
        instr_done = 1'b0;
        step();
        step();
        step();
    endtask

    // Monitor: every accepted pop is compared with the scoreboard; held words must not change.
    logic        prev_hold = 1'b0;
    logic [15:0] prev_iin  = 16'h0000;

    always @(negedge clock) begin
        if (!reset && prev_hold) begin
            tests++;
            if (!iin_valid || iin !== prev_iin) begin
                fails++;
                $display("FAIL iin_stable: got %0h/%0b expected %0h/1", iin, iin_valid, prev_iin);
            end
        end
        if (!reset && iin_valid && instr_done && !branch_en) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pop: got %0h expected none", iin);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (iin !== e) begin
                    fails++;
                    $display("FAIL pop_data: got %0h expected %0h", iin, e);
                end
            end
        end
        prev_hold = !reset && iin_valid && !instr_done && !branch_en;
        prev_iin  = iin;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset       = 1'b1;
        instr_done  = 1'b0;
        branch_en   = 1'b0;
        branch_addr = 8'h00;
        halt        = 1'b0;
        step();
        step();
        chk("rst_mem_rd", {31'd0, mem_rd}, 0);
        chk("rst_valid", {31'd0, iin_valid}, 0);
        chk("rst_iin", {16'd0, iin}, 32'h0000);

        // Reset release and fill
        reset = 1'b0;
        #1;
        chk("c0_rd", {31'd0, mem_rd}, 1);
        chk("c0_addr", {24'd0, mem_addr}, 32'h00);
        step(); #1;
        chk("c1_rd", {31'd0, mem_rd}, 1);
        chk("c1_addr", {24'd0, mem_addr}, 32'h01);
        chk("c1_valid", {31'd0, iin_valid}, 0);
        step(); #1;
        chk("c2_valid", {31'd0, iin_valid}, 1);
        chk("c2_iin", {16'd0, iin}, 32'h1000);
        chk("c2_rd", {31'd0, mem_rd}, 0);
        step(); #1;
        chk("full_rd", {31'd0, mem_rd}, 0);
        step(); #1;
        chk("full_rd2", {31'd0, mem_rd}, 0);

        // Paced pops
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(16'h1000 + 16'(k));
            pop_pulse();
        end

        // Branch coinciding with instr_done while a read is in flight
        exp_q.push_back(16'h1003);
        instr_done = 1'b1;
        step();
        instr_done = 1'b0;
        #1;
        chk("pre_br_rd", {31'd0, mem_rd}, 1);
        chk("pre_br_addr", {24'd0, mem_addr}, 32'h05);
        step();
        branch_en   = 1'b1;
        branch_addr = 8'h40;
        instr_done  = 1'b1;
        #1;
        chk("br_no_rd", {31'd0, mem_rd}, 0);
        step();
        branch_en  = 1'b0;
        instr_done = 1'b0;
        #1;
        chk("br_flushed", {31'd0, iin_valid}, 0);
        chk("br_rd", {31'd0, mem_rd}, 1);
        chk("br_addr", {24'd0, mem_addr}, 32'h40);
        step(); #1;
        chk("br_addr2", {24'd0, mem_addr}, 32'h41);
        chk("br_stale", {31'd0, iin_valid}, 0);
        step(); #1;
        chk("br_valid", {31'd0, iin_valid}, 1);
        chk("br_iin", {16'd0, iin}, 32'h1040);
        exp_q.push_back(16'h1040);
        exp_q.push_back(16'h1041);
        pop_pulse();
        pop_pulse();

        // PC wrap at 8'hFF
        branch_en   = 1'b1;
        branch_addr = 8'hFE;
        step();
        branch_en = 1'b0;
        #1;
        chk("wrap_addr_fe", {24'd0, mem_addr}, 32'hFE);
        step(); #1;
        chk("wrap_addr_ff", {24'd0, mem_addr}, 32'hFF);
        step();
        step(); #1;
        chk("wrap_full_rd", {31'd0, mem_rd}, 0);
        exp_q.push_back(16'h10FE);
        instr_done = 1'b1;
        step();
        instr_done = 1'b0;
        #1;
        chk("wrap_rd", {31'd0, mem_rd}, 1);
        chk("wrap_addr_00", {24'd0, mem_addr}, 32'h00);
        step();
        step();

        // Halt while draining
        exp_q.push_back(16'h10FF);
        exp_q.push_back(16'h1000);
        halt = 1'b1;
        for (int i = 0; i < 10; i++) begin
            instr_done = (i == 2 || i == 5);
            #1;
            chk("halt_no_rd", {31'd0, mem_rd}, 0);
            step();
        end
        instr_done = 1'b0;
        chk("halt_empty", {31'd0, iin_valid}, 0);
        halt = 1'b0;
        #1;
        n = 0;
        while (!mem_rd && n < 4) begin
            step(); #1;
            n++;
        end
        chk("resume_rd", {31'd0, mem_rd}, 1);
        chk("resume_addr", {24'd0, mem_addr}, 32'h01);

        // Reset with a read in flight, then 5 pops and a branch
        step();
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, iin_valid}, 0);
        chk("mid_rst_rd", {31'd0, mem_rd}, 0);
`ifdef IFETCH_STATS_EN
        chk("stats_rst", {16'd0, fetch_count}, 0);
`endif
        step();
        reset = 1'b0;
        step();
        step();
        step();
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back(16'h1000 + 16'(k));
            pop_pulse();
        end
        branch_en   = 1'b1;
        branch_addr = 8'h10;
        instr_done  = 1'b1;
        step();
        branch_en  = 1'b0;
        instr_done = 1'b0;
        #1;
`ifdef IFETCH_STATS_EN
        chk("stats_five", {16'd0, fetch_count}, 5);
`endif
        reset = 1'b1;
        #1;
`ifdef IFETCH_STATS_EN
        chk("stats_zero", {16'd0, fetch_count}, 0);
`endif
        chk("end_rst_valid", {31'd0, iin_valid}, 0);
        step();
        reset = 1'b0;
        step();
        chk("sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
